// File: rtl/coriolis_ker1_subker1_y_yn_rxfifo.sv
// Receive-side FWFT elastic FIFO with almost-full flag; 1-cycle latency, iready only from registered count.
// Optional stall counter port enabled by defining COR_RXFIFO_STATS_EN.
module coriolis_ker1_subker1_y_yn_rxfifo #(
  parameter int STREAMW      = 34,
  parameter int SIZE         = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1_s0,
  input  logic [STREAMW-1:0] in1_s0,
  output logic               iready,
  output logic               afull,
  output logic               ovalid_out1_s0,
  input  logic               oready_out1_s0,
  output logic [STREAMW-1:0] out1_s0
`ifdef COR_RXFIFO_STATS_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int AW = $clog2(SIZE);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(SIZE);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(SIZE - AFULL_MARGIN);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [STREAMW-1:0] mem [SIZE];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               push;
  logic               pop;

  // Flags come only from count, so downstream ready never reaches iready combinationally.
  assign iready         = (count != FULL_CNT);
  assign ovalid_out1_s0 = (count != '0);
  assign afull          = (count >= AFULL_CNT);
  assign out1_s0        = ovalid_out1_s0 ? mem[rd_ptr] : '0;

  assign push = ivalid_in1_s0 & iready;
  assign pop  = ovalid_out1_s0 & oready_out1_s0;

  // Storage is deliberately not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in1_s0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef COR_RXFIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ovalid_out1_s0 && !oready_out1_s0 && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coriolis_ker1_subker1_y_yn_rxfifo.sv
// Scoreboard bench for the receive FIFO: directed stimulus pushes expected words, a negedge monitor checks pops.
module tb_coriolis_ker1_subker1_y_yn_rxfifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ivalid_in1_s0 = 1'b0;
  logic [33:0] in1_s0 = '0;
  logic        iready;
  logic        afull;
  logic        ovalid_out1_s0;
  logic        oready_out1_s0 = 1'b0;
  logic [33:0] out1_s0;
`ifdef COR_RXFIFO_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q [$];

  coriolis_ker1_subker1_y_yn_rxfifo #(
    .STREAMW(34), .SIZE(16), .AFULL_MARGIN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ivalid_in1_s0(ivalid_in1_s0),
    .in1_s0(in1_s0),
    .iready(iready),
    .afull(afull),
    .ovalid_out1_s0(ovalid_out1_s0),
    .oready_out1_s0(oready_out1_s0),
    .out1_s0(out1_s0)
`ifdef COR_RXFIFO_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && ovalid_out1_s0 && oready_out1_s0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected no output", out1_s0);
      end else begin
        logic [33:0] want;
        want = exp_q.pop_front();
        if (out1_s0 !== want) begin
          failures++;
          $display("FAIL sb_data: got 0x%0h expected 0x%0h", out1_s0, want);
        end
      end
    end
  end

  initial begin
    // 1. reset for three cycles
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_iready", 64'(iready), 64'd1);
    check("rst_ovalid", 64'(ovalid_out1_s0), 64'd0);
    check("rst_out", 64'(out1_s0), 64'd0);
    check("rst_afull", 64'(afull), 64'd0);
    step();

    // 2. single word, one-cycle latency, no bypass
    ivalid_in1_s0 = 1'b1; in1_s0 = 34'h2A; exp_q.push_back(34'h2A);
    check("empty_no_bypass", 64'(ovalid_out1_s0), 64'd0);
    step();
    ivalid_in1_s0 = 1'b0; in1_s0 = 34'h3FF;
    check("lat_ovalid", 64'(ovalid_out1_s0), 64'd1);
    check("lat_data", 64'(out1_s0), 64'h2A);
    oready_out1_s0 = 1'b1;
    step();
    oready_out1_s0 = 1'b0;
    check("pop_empty", 64'(ovalid_out1_s0), 64'd0);

    // 3. fill to full with the output stalled
    for (int i = 1; i <= 16; i++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = 34'(i); exp_q.push_back(34'(i));
      step();
      if (i == 13) check("afull_after13", 64'(afull), 64'd0);
      if (i == 14) check("afull_after14", 64'(afull), 64'd1);
      if (i == 15) check("iready_after15", 64'(iready), 64'd1);
      if (i == 16) check("iready_after16", 64'(iready), 64'd0);
    end
    ivalid_in1_s0 = 1'b1; in1_s0 = 34'd17;
    repeat (3) step();
    check("full_hold_iready", 64'(iready), 64'd0);
    check("full_head_stable", 64'(out1_s0), 64'd1);
    ivalid_in1_s0 = 1'b0;

    // 4. drain; space is visible only after the first pop edge
    oready_out1_s0 = 1'b1;
    #1;
    check("no_comb_ready_path", 64'(iready), 64'd0);
    step();
    check("iready_after_pop", 64'(iready), 64'd1);
    repeat (15) step();
    check("drained_ovalid", 64'(ovalid_out1_s0), 64'd0);
    check("drained_out", 64'(out1_s0), 64'd0);
    check("drained_queue", 64'(exp_q.size()), 64'd0);

    // 5. prefill 5 then stream push+pop for 40 cycles across wraps
    oready_out1_s0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = 34'(12'h100 + i); exp_q.push_back(34'(12'h100 + i));
      step();
    end
    oready_out1_s0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = 34'(12'h200 + i); exp_q.push_back(34'(12'h200 + i));
      step();
    end
    check("steady_afull", 64'(afull), 64'd0);
    check("steady_queue", 64'(exp_q.size()), 64'd5);
    ivalid_in1_s0 = 1'b0; in1_s0 = 34'h3_DEAD_BEEF;
    repeat (4) step();
    check("steady_count4", 64'(ovalid_out1_s0), 64'd1);
    step();
    check("steady_count5", 64'(ovalid_out1_s0), 64'd0);

    // 6. mid-stream asynchronous reset with nine words held
    oready_out1_s0 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      ivalid_in1_s0 = 1'b1; in1_s0 = 34'(12'h300 + i); exp_q.push_back(34'(12'h300 + i));
      step();
    end
    ivalid_in1_s0 = 1'b0;
    repeat (2) step();
    check("nine_ovalid", 64'(ovalid_out1_s0), 64'd1);
    check("nine_afull", 64'(afull), 64'd0);
`ifdef COR_RXFIFO_STATS_EN
    check("stall_cnt_10", 64'(stall_cnt), 64'd10);
`endif
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_ovalid", 64'(ovalid_out1_s0), 64'd0);
    check("arst_iready", 64'(iready), 64'd1);
    check("arst_out", 64'(out1_s0), 64'd0);
`ifdef COR_RXFIFO_STATS_EN
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    step();
    rst = 1'b0;
    ivalid_in1_s0 = 1'b1; in1_s0 = 34'h55; exp_q.push_back(34'h55);
    step();
    ivalid_in1_s0 = 1'b0;
    check("post_rst_data", 64'(out1_s0), 64'h55);
    oready_out1_s0 = 1'b1;
    step();
    oready_out1_s0 = 1'b0;
    check("post_rst_empty", 64'(ovalid_out1_s0), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
